// File: rtl/ecg_frame_reader_if.sv
// ---------------------------------------------------------------------------
// ecg_frame_reader_if
// Bus bundle for ecg_frame_reader: the buffer-RAM read port and the outgoing
// sample stream.
//   rd_addr  : RAM read address (MSB selects the bank)
//   rd_en    : RAM read strobe
//   rd_data  : RAM read data, valid exactly one cycle after rd_en
//   m_data   : outgoing sample
//   m_valid  : sample valid
//   m_ready  : downstream accepts the sample
//   m_last   : marks the final sample of a frame
// master = the frame reader, slave = the RAM and stream consumer side.
// ---------------------------------------------------------------------------
interface ecg_frame_reader_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output rd_addr, rd_en, m_data, m_valid, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_addr, rd_en, m_data, m_valid, m_last,
        output rd_data, m_ready
    );
endinterface

// File: rtl/ecg_frame_reader.sv
// ---------------------------------------------------------------------------
// ecg_frame_reader
// Reads completed ECG frames out of a double-buffered sample RAM and streams
// them with a valid/ready handshake. A toggle on 'switch' marks the bank that
// was being written as complete; the reader then fetches N = load samples from
// that bank in ascending order and presents them on the stream, with m_last on
// the final sample. One further frame may queue up while a frame is in
// progress; any frame beyond that is lost and flagged on the sticky 'overrun'.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   load     : samples per frame (latched when a frame is accepted)
//   switch   : bank currently being written upstream
//   bus      : RAM read port + sample stream (master side)
//   busy     : a frame is being read or drained
//   overrun  : sticky, a frame boundary was lost
// ---------------------------------------------------------------------------
module ecg_frame_reader #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         load,
    input  logic                switch,
    ecg_frame_reader_if.master  bus,
    output logic                busy,
    output logic                overrun
);

    localparam int IDX_W = ADDR_W - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic              r_switch_d;
    logic              r_bank;
    logic [10:0]       r_n;
    logic [10:0]       r_rd_idx;
    logic              r_pend_vld;
    logic              r_pend_bank;
    logic [10:0]       r_pend_n;
    logic              r_overrun;
    logic              r_inflight_p1;
    logic              r_inflight_last_p1;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_b0_data;
    logic              r_b0_last;
    logic [DATA_W-1:0] r_b1_data;
    logic              r_b1_last;

    logic              w_toggle;
    logic              w_pop;
    logic              w_push;
    logic              w_last_xfer;
    logic [2:0]        w_occ;
    logic              w_rd_en;
    logic              w_start;
    logic              w_start_bank;
    logic [10:0]       w_start_n;

    assign w_toggle    = (switch != r_switch_d);
    assign w_pop       = (r_cnt != 2'd0) && bus.m_ready;
    assign w_push      = r_inflight_p1;
    assign w_last_xfer = w_pop && r_b0_last;

    // Occupancy the buffer will have once this cycle's transfer and the
    // in-flight sample settle; issuing only below 2 guarantees a free slot for
    // every read, and crediting the pop keeps one sample per cycle.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight_p1} - {2'b00, w_pop};
    assign w_rd_en = (r_state == S_READ) && (r_rd_idx < r_n) && (w_occ < 3'd2);

    // A new frame starts either from IDLE on a toggle, or straight after the
    // m_last transfer from the pending slot (or a toggle arriving that cycle).
    always_comb begin
        w_start      = 1'b0;
        w_start_bank = r_switch_d;
        w_start_n    = load;
        if (r_state == S_IDLE) begin
            w_start = w_toggle;
        end else if (w_last_xfer) begin
            if (r_pend_vld) begin
                w_start      = 1'b1;
                w_start_bank = r_pend_bank;
                w_start_n    = r_pend_n;
            end else if (w_toggle) begin
                w_start = 1'b1;
            end
        end
    end

    // ---- frame control / read issue ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_switch_d         <= 1'b0;
            r_bank             <= 1'b0;
            r_n                <= '0;
            r_rd_idx           <= '0;
            r_pend_vld         <= 1'b0;
            r_pend_bank        <= 1'b0;
            r_pend_n           <= '0;
            r_overrun          <= 1'b0;
            r_inflight_p1      <= 1'b0;
            r_inflight_last_p1 <= 1'b0;
        end else begin
            r_switch_d <= switch;

            if (w_start) begin
                r_bank   <= w_start_bank;
                r_n      <= w_start_n;
                r_rd_idx <= '0;
                r_state  <= (w_start_n != 11'd0) ? S_READ : S_IDLE;
            end else begin
                if (w_rd_en) begin
                    r_rd_idx <= r_rd_idx + 11'd1;
                end
                if ((r_state == S_READ) && w_rd_en && (r_rd_idx == r_n - 11'd1)) begin
                    r_state <= S_DRAIN;
                end
                if ((r_state == S_DRAIN) && w_last_xfer) begin
                    r_state <= S_IDLE;
                end
            end

            if (w_last_xfer && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end
            // A toggle coinciding with m_last and no pending frame is started
            // directly by w_start, so it never occupies the pending slot.
            if (w_toggle && (r_state != S_IDLE)) begin
                if (r_pend_vld) begin
                    r_overrun <= 1'b1;
                end else if (!w_last_xfer) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_bank <= r_switch_d;
                    r_pend_n    <= load;
                end
            end

            r_inflight_p1      <= w_rd_en;
            r_inflight_last_p1 <= (r_rd_idx == r_n - 11'd1);
        end
    end

    // ---- output buffer head (drives the stream) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 2'd0;
            r_b0_data <= '0;
            r_b0_last <= 1'b0;
        end else begin
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop && (r_cnt == 2'd2)) begin
                r_b0_data <= r_b1_data;
                r_b0_last <= r_b1_last;
            end else if (w_push && ((r_cnt == 2'd0) || (w_pop && (r_cnt == 2'd1)))) begin
                r_b0_data <= bus.rd_data;
                r_b0_last <= r_inflight_last_p1;
            end
        end
    end

    // ---- output buffer second slot ----
    always_ff @(posedge clk) begin
        if (w_push && (((r_cnt == 2'd1) && !w_pop) || ((r_cnt == 2'd2) && w_pop))) begin
            r_b1_data <= bus.rd_data;
            r_b1_last <= r_inflight_last_p1;
        end
    end

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = {r_bank, IDX_W'(r_rd_idx)};
    assign bus.m_data  = r_b0_data;
    assign bus.m_last  = r_b0_last;
    assign bus.m_valid = (r_cnt != 2'd0);
    assign busy        = (r_state != S_IDLE);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_ecg_frame_reader.sv
module tb_ecg_frame_reader;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] load = '0;
    logic        sw = 1'b0;
    logic        busy;
    logic        overrun;

    ecg_frame_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    ecg_frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .switch  (sw),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    // RAM: one-cycle read latency; garbage on the bus when not read
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
        else           bus.rd_data <= DATA_W'($urandom);
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W:0]   exp_smp[$];
    int frames_q = 0;
    int n_xfer = 0;
    int act_cnt = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame of n samples from a bank is the run of
    // addresses base..base+n-1 with the final one flagged last.
    task automatic push_frame(input bit bank, input int n);
        int base;
        logic [ADDR_W-1:0] a;
        base = bank ? (1 << (ADDR_W-1)) : 0;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(base + i);
            exp_addr.push_back(a);
            exp_smp.push_back({(i == n-1), ram[a]});
        end
        if (n > 0) frames_q++;
    endtask

    task automatic drive_toggle(input int n, input bit accept);
        bit bank;
        bank = sw;
        load = 11'(n);
        sw = ~sw;
        if (accept) push_frame(bank, n);
    endtask

    task automatic do_toggle(input int n, input bit accept);
        @(posedge clk); #1;
        drive_toggle(n, accept);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (exp_smp.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", longint'(done), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, longint'(bus.m_valid), 0);
        chk({tag, "_m_last"},  longint'(bus.m_last), 0);
        chk({tag, "_m_data"},  longint'(bus.m_data), 0);
        chk({tag, "_rd_en"},   longint'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, longint'(bus.rd_addr), 0);
        chk({tag, "_busy"},    longint'(busy), 0);
        chk({tag, "_overrun"}, longint'(overrun), 0);
    endtask

    // m_ready driver: 0 always 1, 1 pattern 1,0,0,1, 2 random, 3 always 0
    initial begin
        int ph;
        ph = 0;
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2: bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
            ph++;
        end
    end

    // Monitor: read addresses, stream samples and stall stability
    logic              prev_v = 1'b0;
    logic              prev_r = 1'b0;
    logic              prev_l = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (busy || bus.rd_en || bus.m_valid) act_cnt++;
            if (bus.rd_en) begin
                if (exp_addr.size() == 0) chk("unexpected_rd_en", 1, 0);
                else chk("rd_addr", longint'(bus.rd_addr), longint'(exp_addr.pop_front()));
            end
            if (prev_v && !prev_r) begin
                chk("stall_hold", longint'({bus.m_valid, bus.m_last, bus.m_data}),
                    longint'({1'b1, prev_l, prev_d}));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_smp.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_smp.pop_front();
                    chk("m_data", longint'(bus.m_data), longint'(e[DATA_W-1:0]));
                    chk("m_last", longint'(bus.m_last), longint'(e[DATA_W]));
                    if (e[DATA_W]) frames_q--;
                end
                n_xfer++;
            end
            prev_v = bus.m_valid;
            prev_r = bus.m_ready;
            prev_l = bus.m_last;
            prev_d = bus.m_data;
        end
    end

    initial begin
        int first_c, last_c, nv, base, n;
        bit b12, b13, reached;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 10-sample frame from bank 0, full throughput, latency and busy
        ready_mode = 0;
        do_toggle(10, 1);
        first_c = -1; last_c = -1; nv = 0; b12 = 0; b13 = 1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (bus.m_valid) begin
                nv++;
                if (first_c < 0) first_c = c;
                if (bus.m_last) last_c = c;
            end
            if (c == 12) b12 = busy;
            if (c == 13) b13 = busy;
        end
        chk("first_valid_cycle", first_c, 3);
        chk("last_cycle", last_c, 12);
        chk("valid_cycles", nv, 10);
        chk("busy_before_last", longint'(b12), 1);
        chk("busy_after_last", longint'(b13), 0);
        wait_idle(200);

        // 4 samples from bank 1
        do_toggle(4, 1);
        wait_idle(200);

        // 8 samples with ready pattern 1,0,0,1
        ready_mode = 1;
        do_toggle(8, 1);
        wait_idle(300);

        // back-pressure: pending frame then overrun
        ready_mode = 3;
        do_toggle(20, 1);
        repeat (5) @(posedge clk);
        do_toggle(6, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_after_pending", longint'(overrun), 0);
        do_toggle(7, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("overrun_set", longint'(overrun), 1);
        chk("busy_stalled", longint'(busy), 1);
        ready_mode = 0;
        wait_idle(400);
        chk("overrun_sticky", longint'(overrun), 1);

        // zero-length frame is discarded
        act_cnt = 0;
        do_toggle(0, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("zero_frame_activity", act_cnt, 0);

        // reset mid-frame after 5 of 10 samples; switch left at 0
        if (sw == 1'b0) begin
            do_toggle(0, 0);
            repeat (3) @(posedge clk);
        end
        ready_mode = 0;
        do_toggle(10, 1);
        base = n_xfer;
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (n_xfer - base >= 5) begin
                reached = 1;
                break;
            end
        end
        chk("five_delivered", longint'(reached), 1);
        #1;
        rst_n = 1'b0;
        exp_addr.delete();
        exp_smp.delete();
        frames_q = 0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        act_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_activity", act_cnt, 0);

        // randomized frames, random back-pressure, at most one frame queued
        ready_mode = 2;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 40);
            reached = 0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge clk); #1;
                if (frames_q <= 1) begin
                    reached = 1;
                    break;
                end
            end
            chk("slot_timeout", longint'(reached), 1);
            drive_toggle(n, 1);
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end
        wait_idle(4000);
        chk("random_overrun", longint'(overrun), 0);
        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("sample_queue_empty", exp_smp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ecg_frame_reader.md
ECG_FRAME_READER -- requirements
Module: ecg_frame_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width.
REQ-002 SHALL have parameter ADDR_W, default 12, buffer RAM address width; bit ADDR_W-1 selects the bank.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port load, input, 11, samples per frame (N), same value given to the address counter.
REQ-006 SHALL have port switch, input, 1, bank currently written by the upstream address counter (0 = bank 0, 1 = bank 1).
REQ-007 SHALL have port rd_addr, output, ADDR_W, RAM read address.
REQ-008 SHALL have port rd_en, output, 1, RAM read strobe.
REQ-009 SHALL have port rd_data, input, DATA_W, RAM read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have ports m_data (output, DATA_W), m_valid (output, 1), m_ready (input, 1), m_last (output, 1), sample stream out.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port overrun, output, 1, sticky frame-loss flag.

Function
REQ-013 SHALL register switch (switch_d); any toggle (switch != switch_d) marks bank switch_d complete.
REQ-014 SHALL, on a toggle in IDLE, latch bank = switch_d and N = load, and enter READ if N != 0; N = 0 frames are discarded silently, no output.
REQ-015 SHALL read addresses {bank, 0..N-1} in ascending order; bank base is 0 or 2^(ADDR_W-1); no wrap into the other bank (N <= 2047 < 2048).
REQ-016 SHALL keep a 2-entry output buffer; rd_en asserts only when (buffered + in-flight) < 2 and reads remain, so no sample is ever dropped under back-pressure.
REQ-017 SHALL, with m_ready held 1, sustain one sample per cycle; first m_valid 2 cycles after the toggle is seen on switch.
REQ-018 SHALL hold m_data/m_last stable while m_valid=1 and m_ready=0; transfer occurs when m_valid & m_ready.
REQ-019 SHALL assert m_last with sample N-1 of the frame only.
REQ-020 SHALL use states IDLE -> READ (issuing reads) -> DRAIN (all reads issued, buffer non-empty) -> IDLE after the m_last transfer.
REQ-021 SHALL assert busy in READ and DRAIN.
REQ-022 SHALL, on a toggle while busy with no frame pending, record one pending frame (bank, load); it starts in the cycle after the current frame's m_last transfer.
REQ-023 SHALL, on a toggle while busy with a frame already pending, set overrun=1 and keep the existing pending frame unchanged.
REQ-024 SHALL, on a toggle in the same cycle as the m_last transfer, treat it as pending and start it next cycle without overrun.
REQ-025 SHALL keep overrun set until reset.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, rd_addr=0, rd_en=0, m_data=0, m_valid=0, m_last=0, busy=0, overrun=0, switch_d=0, pending cleared, buffer emptied.
REQ-027 SHALL abandon any frame in progress on reset assertion; in-flight RAM data is discarded.
REQ-028 SHALL take the first switch toggle after reset release as a frame boundary.

Verification
REQ-029 SHALL: load=10, switch 0->1, m_ready=1 -> rd_addr 0..9, m_data = RAM[0..9] on 10 consecutive cycles, m_last on 10th, busy drops after.
REQ-030 SHALL: load=4, switch 1->0 -> rd_addr 2048..2051, four samples, m_last on RAM[2051].
REQ-031 SHALL: load=8, m_ready toggling 1,0,0,1 pattern -> all 8 samples delivered in order, no duplicates, data stable during stalls.
REQ-032 SHALL: load=20, m_ready=0 throughout frame, two further toggles -> first sets pending, second sets overrun=1; pending frame delivered after m_ready=1.
REQ-033 SHALL: load=0 toggle -> no rd_en, no m_valid, busy stays 0.
REQ-034 SHALL: rst_n low mid-frame (after 5 of 10 samples) -> all outputs 0 within reset; after release no further samples until next toggle.
